seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_if.sv | 15 +
 rtl/seq_multiplier.sv | 82 ++++++++
 tb/tb_seq_multiplier.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for the sequential shift-add multiplier.
// The master drives the operands and start; the slave returns the product and status.
interface seq_multiplier_if #(
  parameter int N = 4
);
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           start;
  logic [2*N-1:0] p;
  logic           busy;
  logic           valid;

  modport master (output a, output b, output start, input p, input busy, input valid);
  modport slave  (input a, input b, input start, output p, output busy, output valid);
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned N x N sequential multiplier: one shift-add step per cycle, fixed N-cycle
// latency, with the product held until the next operation completes.
module seq_multiplier #(
  parameter int N = 4
) (
  input logic            clk,
  input logic            rst_n,
  seq_multiplier_if.slave bus
);
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2*N-1:0]   r_mcand;
  logic [N-1:0]     r_mplier;
  logic [2*N-1:0]   r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [2*N-1:0]   r_p;
  logic             r_busy;
  logic             r_valid;

  logic             w_accept;
  logic             w_last;
  logic [2*N-1:0]   w_sum;

  assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == CALC) && (r_cnt == CNT_W'(N - 1));
  // Accumulator after the current step; on the last step this is the product.
  assign w_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = CALC;
      CALC:    if (w_last)    w_next = DONE;
      DONE:    w_next = bus.start ? CALC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_p      <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_mcand  <= {{N{1'b0}}, bus.a};
        r_mplier <= bus.b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else if (r_state == CALC) begin
        r_acc    <= w_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_p     <= w_sum;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  assign bus.p     = r_p;
  assign bus.busy  = r_busy;
  assign bus.valid = r_valid;
endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: a per-cycle reference model built on a*b and a latency
// countdown, a vector table, hand-written corner sequences and random traffic.
module tb_seq_multiplier;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_multiplier_if #(.N(N)) bus ();
  seq_multiplier #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: remaining edges until the result appears.
  int             m_rem = 0;
  logic [2*N-1:0] m_p = '0;
  logic [2*N-1:0] m_prod = '0;
  logic           m_valid = 1'b0;
  logic           m_acc = 1'b0;
  int             n_valid = 0;
  int             n_accept = 0;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] exp_p;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then compare.
  task automatic cyc(input logic s, input logic [N-1:0] ia, input logic [N-1:0] ib,
                     input logic r);
    bus.start = s;
    bus.a     = ia;
    bus.b     = ib;
    rst_n     = r;
    @(posedge clk);
    m_acc = 1'b0;
    if (!r) begin
      m_rem   = 0;
      m_p     = '0;
      m_valid = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      m_valid = (m_rem == 0);
      if (m_rem == 0) m_p = m_prod;
    end else begin
      m_valid = 1'b0;
      if (s) begin
        m_prod = (2*N)'(ia) * (2*N)'(ib);
        m_rem  = N;
        m_acc  = 1'b1;
      end
    end
    if (m_valid) n_valid++;
    if (m_acc) n_accept++;
    #1;
    check("p", 32'(bus.p), 32'(m_p));
    check("busy", 32'(bus.busy), 32'(m_rem > 0));
    check("valid", 32'(bus.valid), 32'(m_valid));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    int lat;
    int v0;
    int a0;
    int idx;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  exp_p: 8'd15};
    vecs[1] = '{a: 4'd15, b: 4'd15, exp_p: 8'd225};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  exp_p: 8'd0};
    vecs[3] = '{a: 4'd15, b: 4'd0,  exp_p: 8'd0};
    vecs[4] = '{a: 4'd1,  b: 4'd15, exp_p: 8'd15};
    vecs[5] = '{a: 4'd8,  b: 4'd8,  exp_p: 8'd64};
    vecs[6] = '{a: 4'd12, b: 4'd10, exp_p: 8'd120};
    vecs[7] = '{a: 4'd7,  b: 4'd1,  exp_p: 8'd7};

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    cyc(1'b0, '0, '0, 1'b0);
    cyc(1'b1, 4'd5, 4'd5, 1'b0);
    check("rst_p", 32'(bus.p), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_valid", 32'(bus.valid), 0);

    // Table: fixed latency of N edges after the accepting edge, and the product.
    foreach (vecs[i]) begin
      cyc(1'b1, vecs[i].a, vecs[i].b, 1'b1);
      check("tbl_busy", 32'(bus.busy), 1);
      lat = 0;
      do begin
        cyc(1'b0, '0, '0, 1'b1);
        lat++;
      end while (!bus.valid && lat < 12);
      check("tbl_lat", lat, N);
      check("tbl_p", 32'(bus.p), 32'(vecs[i].exp_p));
      check("tbl_busy_done", 32'(bus.busy), 0);
      idle(1);
      check("tbl_valid_fall", 32'(bus.valid), 0);
      check("tbl_p_hold", 32'(bus.p), 32'(vecs[i].exp_p));
    end

    // start and operand changes during CALC are ignored.
    v0 = n_valid;
    cyc(1'b1, 4'd6, 4'd7, 1'b1);
    cyc(1'b0, 4'd6, 4'd7, 1'b1);
    cyc(1'b1, 4'd1, 4'd1, 1'b1);
    cyc(1'b0, 4'd1, 4'd1, 1'b1);
    cyc(1'b0, 4'd1, 4'd1, 1'b1);
    check("calc_ign_valid", 32'(bus.valid), 1);
    check("calc_ign_p", 32'(bus.p), 42);
    idle(8);
    check("calc_ign_pulses", n_valid - v0, 1);

    // Back-to-back start during the valid cycle.
    cyc(1'b1, 4'd2, 4'd3, 1'b1);
    idle(3);
    cyc(1'b0, 4'd4, 4'd4, 1'b1);
    check("b2b_valid1", 32'(bus.valid), 1);
    check("b2b_p1", 32'(bus.p), 6);
    cyc(1'b1, 4'd4, 4'd4, 1'b1);
    check("b2b_busy", 32'(bus.busy), 1);
    check("b2b_valid_fall", 32'(bus.valid), 0);
    check("b2b_p_hold", 32'(bus.p), 6);
    idle(3);
    check("b2b_no_early", 32'(bus.valid), 0);
    idle(1);
    check("b2b_valid2", 32'(bus.valid), 1);
    check("b2b_p2", 32'(bus.p), 16);
    idle(2);

    // Reset in the middle of CALC aborts with no later pulse.
    v0 = n_valid;
    cyc(1'b1, 4'd9, 4'd9, 1'b1);
    idle(2);
    cyc(1'b0, 4'd9, 4'd9, 1'b0);
    check("abort_p", 32'(bus.p), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_valid", 32'(bus.valid), 0);
    idle(10);
    check("abort_pulses", n_valid - v0, 0);
    cyc(1'b1, 4'd2, 4'd5, 1'b1);
    check("post_rst_accept", 32'(bus.busy), 1);
    idle(N + 1);

    // Exhaustive sweep with start held high: each pair accepted in DONE.
    v0 = n_valid;
    a0 = n_accept;
    idx = 0;
    for (int k = 0; k < 2000 && idx < 256; k++) begin
      cyc(1'b1, N'(idx >> N), N'(idx), 1'b1);
      if (m_acc) idx++;
    end
    idle(N + 2);
    check("exh_count", idx, 256);
    check("exh_accepts", n_accept - a0, 256);
    check("exh_valids", n_valid - v0, 256);

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 2) == 0), N'($urandom), N'($urandom),
          ($urandom_range(0, 40) != 0));
    end
    idle(N + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
